// File: rtl/hazard_if.sv
// Decode-stage hazard inputs and the forwarding/stall controls returned to the pipeline.
// master: pipeline side (drives decode fields); slave: hazard_control.
interface hazard_if #(
    parameter int REG_ADDR_BITS = 5
);
    logic [REG_ADDR_BITS-1:0] rs_d;
    logic [REG_ADDR_BITS-1:0] rt_d;
    logic [REG_ADDR_BITS-1:0] write_reg_d;
    logic                     reg_write_d;
    logic                     mem_to_reg_d;
    logic                     branch_d;
    logic                     mdu_start_d;
    logic                     mdu_use_d;
    logic [1:0]               forward_a_e;
    logic [1:0]               forward_b_e;
    logic                     forward_a_d;
    logic                     forward_b_d;
    logic                     stall_f;
    logic                     stall_d;
    logic                     flush_e;
    logic                     mdu_busy;

    modport master (
        output rs_d, rt_d, write_reg_d, reg_write_d, mem_to_reg_d, branch_d,
               mdu_start_d, mdu_use_d,
        input  forward_a_e, forward_b_e, forward_a_d, forward_b_d,
               stall_f, stall_d, flush_e, mdu_busy
    );

    modport slave (
        input  rs_d, rt_d, write_reg_d, reg_write_d, mem_to_reg_d, branch_d,
               mdu_start_d, mdu_use_d,
        output forward_a_e, forward_b_e, forward_a_d, forward_b_d,
               stall_f, stall_d, flush_e, mdu_busy
    );
endinterface

// File: rtl/hazard_control.sv
// Hazard detection and forwarding control for the five-stage pipeline.
// Define HAZARD_MDU_STALL_EN to include the MDU busy counter and its stall term.
module hazard_control #(
    parameter int REG_ADDR_BITS = 5,
    parameter int MDU_LATENCY   = 32
) (
    input logic     clk,
    input logic     rst_n,
    hazard_if.slave hz
);
    localparam int AW = REG_ADDR_BITS;

    logic [AW-1:0] rs_e_reg, rt_e_reg, wreg_e_reg, wreg_m_reg, wreg_w_reg;
    logic          reg_write_e_reg, reg_write_m_reg, reg_write_w_reg;
    logic          mem_to_reg_e_reg, mem_to_reg_m_reg, mem_to_reg_w_reg;

    logic          lw_stall, br_stall, mdu_stall, stall;
    logic          mdu_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_e_reg         <= '0;
            rt_e_reg         <= '0;
            wreg_e_reg       <= '0;
            reg_write_e_reg  <= 1'b0;
            mem_to_reg_e_reg <= 1'b0;
            wreg_m_reg       <= '0;
            reg_write_m_reg  <= 1'b0;
            mem_to_reg_m_reg <= 1'b0;
            wreg_w_reg       <= '0;
            reg_write_w_reg  <= 1'b0;
            mem_to_reg_w_reg <= 1'b0;
        end else begin
            // A stalled decode instruction must not also enter E: bubble it.
            rs_e_reg         <= stall ? '0   : hz.rs_d;
            rt_e_reg         <= stall ? '0   : hz.rt_d;
            wreg_e_reg       <= stall ? '0   : hz.write_reg_d;
            reg_write_e_reg  <= stall ? 1'b0 : hz.reg_write_d;
            mem_to_reg_e_reg <= stall ? 1'b0 : hz.mem_to_reg_d;
            wreg_m_reg       <= wreg_e_reg;
            reg_write_m_reg  <= reg_write_e_reg;
            mem_to_reg_m_reg <= mem_to_reg_e_reg;
            wreg_w_reg       <= wreg_m_reg;
            reg_write_w_reg  <= reg_write_m_reg;
            mem_to_reg_w_reg <= mem_to_reg_m_reg;
        end
    end

    // Operand 0 is A (rs), operand 1 is B (rt).
    logic [AW-1:0] src_e [2];
    logic [AW-1:0] src_d [2];
    logic [3:0]    fwd_e_all;
    logic [1:0]    fwd_d_all;

    assign src_e[0] = rs_e_reg;
    assign src_e[1] = rt_e_reg;
    assign src_d[0] = hz.rs_d;
    assign src_d[1] = hz.rt_d;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit_m, hit_w;
            assign hit_m = (src_e[gi] != '0) && reg_write_m_reg && (src_e[gi] == wreg_m_reg);
            assign hit_w = (src_e[gi] != '0) && reg_write_w_reg && (src_e[gi] == wreg_w_reg);
            assign fwd_e_all[gi*2 +: 2] = hit_m ? 2'b10 : (hit_w ? 2'b01 : 2'b00);
            assign fwd_d_all[gi] = (src_d[gi] != '0) && reg_write_m_reg && (src_d[gi] == wreg_m_reg);
        end
    endgenerate

    assign hz.forward_a_e = fwd_e_all[1:0];
    assign hz.forward_b_e = fwd_e_all[3:2];
    assign hz.forward_a_d = fwd_d_all[0];
    assign hz.forward_b_d = fwd_d_all[1];

    always_comb begin
        lw_stall = 1'b0;
        br_stall = 1'b0;
        if (mem_to_reg_e_reg && (wreg_e_reg != '0) &&
            ((wreg_e_reg == hz.rs_d) || (wreg_e_reg == hz.rt_d)))
            lw_stall = 1'b1;
        if (hz.branch_d &&
            ((reg_write_e_reg && (wreg_e_reg != '0) &&
              ((wreg_e_reg == hz.rs_d) || (wreg_e_reg == hz.rt_d))) ||
             (mem_to_reg_m_reg && (wreg_m_reg != '0) &&
              ((wreg_m_reg == hz.rs_d) || (wreg_m_reg == hz.rt_d)))))
            br_stall = 1'b1;
    end

`ifdef HAZARD_MDU_STALL_EN
    localparam int CNT_W = $clog2(MDU_LATENCY + 1);
    logic [CNT_W-1:0] mdu_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mdu_cnt_reg <= '0;
        else if (hz.mdu_start_d && !stall)
            mdu_cnt_reg <= CNT_W'(MDU_LATENCY);
        else if (mdu_cnt_reg != '0)
            mdu_cnt_reg <= mdu_cnt_reg - CNT_W'(1);
    end

    assign mdu_busy  = (mdu_cnt_reg != '0);
    assign mdu_stall = mdu_busy && (hz.mdu_start_d || hz.mdu_use_d);
`else
    logic unused_mdu;
    assign unused_mdu = hz.mdu_start_d | hz.mdu_use_d | mem_to_reg_w_reg;
    assign mdu_busy   = 1'b0;
    assign mdu_stall  = 1'b0;
`endif

    assign stall       = lw_stall | br_stall | mdu_stall;
    assign hz.stall_f  = stall;
    assign hz.stall_d  = stall;
    assign hz.flush_e  = stall;
    assign hz.mdu_busy = mdu_busy;

`ifdef HAZARD_MDU_STALL_EN
    logic unused_w;
    assign unused_w = mem_to_reg_w_reg;
`endif
endmodule

// File: doc/hazard_control.md
# hazard_control

Sequential hazard detection and forwarding-control unit for the five-stage MIPS pipeline. It keeps its own copy of each in-flight instruction's destination register and write-control bits for the E, M and W stages. From that state it drives the 2-bit forwarding selects consumed by the execute-stage operand muxes (A and B), the decode-stage branch-compare forwards, and the fetch/decode stall and execute flush signals. It also tracks a fixed-latency multiply/divide unit (MDU) with a busy counter.

## Interface
- REG_ADDR_BITS, 5, register-file address width
- MDU_LATENCY, 32, cycles the MDU stays busy after an accepted start (≥1)

- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- rs_d, rt_d  in  REG_ADDR_BITS  source registers of the instruction in decode
- write_reg_d  in  REG_ADDR_BITS  destination register of the decode instruction
- reg_write_d, mem_to_reg_d, branch_d  in  1  decode control bits
- mdu_start_d, mdu_use_d  in  1  decode instruction starts an MDU op / reads HI/LO
- forward_a_e, forward_b_e  out  2  execute operand select: 00 register file, 01 result_w, 10 alu_out_m
- forward_a_d, forward_b_d  out  1  branch-compare operand taken from alu_out_m
- stall_f, stall_d  out  1  hold the PC and the IF/ID register
- flush_e  out  1  insert a bubble into ID/EX
- mdu_busy  out  1  MDU counter non-zero

## Operation
- State per stage X∈{E,M,W}: write_reg_X, reg_write_X, mem_to_reg_X. E also holds rs_e, rt_e.
- Each edge:
  - If flush_e: E loads a bubble (all fields 0). Otherwise E loads the decode fields.
  - M←E and W←M unconditionally.
- forward_a_e:
  - 10 if rs_e≠0, reg_write_m and rs_e==write_reg_m.
  - Else 01 if rs_e≠0, reg_write_w and rs_e==write_reg_w.
  - Else 00.
  - M has priority over W.
- forward_b_e: same rule using rt_e.
- forward_a_d = rs_d≠0 & reg_write_m & rs_d==write_reg_m. forward_b_d uses rt_d.
- lw_stall = mem_to_reg_e & write_reg_e≠0 & (write_reg_e==rs_d | write_reg_e==rt_d).
- br_stall = branch_d & ((reg_write_e & write_reg_e≠0 & write_reg_e∈{rs_d,rt_d}) | (mem_to_reg_m & write_reg_m≠0 & write_reg_m∈{rs_d,rt_d})).
- mdu_stall = mdu_busy & (mdu_start_d | mdu_use_d).
- stall_f = stall_d = flush_e = lw_stall | br_stall | mdu_stall. All three assert together. Simultaneous causes produce a single stall.
- MDU counter:
  - Loads MDU_LATENCY on an edge where mdu_start_d & !stall_d.
  - Otherwise decrements while non-zero.
  - mdu_busy = (count≠0).
  - Counter width is clog2(MDU_LATENCY+1).

## Timing
- Reset (async, rst_n low): all E/M/W fields 0, counter 0. Consequently forward_*: 00/0, stall_f/stall_d/flush_e 0, mdu_busy 0, regardless of decode inputs.
- All outputs are combinational from registered state plus current decode inputs, with zero-cycle latency. There are no registered outputs.
- Load-use: exactly one stall cycle per dependent lw. The cycle after, the lw is in M, and E forwarding selects 01 from W one cycle later.
- A branch that depends on an E-stage ALU result stalls 1 cycle. A branch that depends on an E-stage lw stalls 2 cycles (the E condition, then the M condition).
- MDU: mdu_busy rises the cycle after the accepting edge and stays high exactly MDU_LATENCY cycles. A use in the cycle busy falls proceeds without stall.
- Reset asserted mid-stall or mid-MDU operation clears all state immediately. There is no pending stall after release.
- Register 0 never causes forwarding or a stall.

## Configuration
- HAZARD_MDU_STALL_EN defined: MDU counter, mdu_stall term and mdu_busy logic are present.
- Not defined: counter removed, mdu_start_d/mdu_use_d ignored, mdu_busy tied 0, and stalls derive only from lw_stall | br_stall.

## Test plan
- Back-to-back ALU ops: add $3 then sub using $3 as rt -> forward_b_e=10 in the sub's E cycle. With one unrelated instruction between them -> 01. With two -> 00.
- Both M and W write $5, and E reads $5 as rs -> forward_a_e=10 (M priority). Reading $0 with writes to $0 -> 00.
- lw $4, then add reading $4 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle, then forward_b_e/forward_a_e=01.
- beq on $6 directly after lw $6 -> stall 2 cycles, then forward_a_d=0. beq on $7 after add $7 -> 1 stall, then forward_a_d=1.
- MDU_LATENCY=4 with HAZARD_MDU_STALL_EN: mult accepted, then mfhi issued next -> mdu_busy high 4 cycles, mfhi stalled while busy and released when busy falls. Without the macro, no stall.
- Pull rst_n low during the MDU busy interval and during a lw stall -> all outputs 0 asynchronously, mdu_busy 0 after release.
